// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Wishbone classic burst master; define WB_BURST_TIMEOUT_EN to add the ack watchdog
module wb_burst_master #(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [7:0]    cmd_len_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]    wb_cti_o,
    input  logic          wb_ack_i,
    input  logic [DW-1:0] wb_dat_i
);

    localparam int SW = DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The watchdog compare needs at least one cycle of budget.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    logic [1:0]    state;
    logic          rst_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic          hold_full;
    logic [DW-1:0] hold_data;

    logic in_xfer;
    logic stb;
    logic ack_ok;
    logic last_beat;
    logic cmd_fire;
    logic wr_fire;
    logic abort;

    assign in_xfer   = (state == ST_XFER);
    // Reads strobe every cycle; writes only strobe once the hold register has a word.
    assign stb       = in_xfer && (we_q ? hold_full : 1'b1);
    // An ack with the strobe low belongs to nobody and is dropped here.
    assign ack_ok    = stb && wb_ack_i;
    assign last_beat = (beat_q == len_q);

    // rst_q keeps cmd_ready_o low through the cycle that follows the last reset edge.
    assign cmd_ready_o = (state == ST_IDLE) && !rst_q;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign wr_ready_o  = in_xfer && we_q && !hold_full;
    assign wr_fire     = wr_valid_i && wr_ready_o;

    assign busy_o    = (state == ST_XFER) || (state == ST_DONE);
    assign done_o    = (state == ST_DONE);
    assign wb_cyc_o  = in_xfer;
    assign wb_stb_o  = stb;
    assign wb_we_o   = in_xfer && we_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = hold_data;
    assign wb_sel_o  = {SW{in_xfer}};
    assign wb_cti_o  = !in_xfer ? 3'b000 : (last_beat ? 3'b111 : 3'b010);

`ifdef WB_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Fires on the TIMEOUT-th consecutive strobed cycle without an ack.
    assign abort = stb && !wb_ack_i && (to_cnt == TW'(TIMEOUT - 1));
    assign err_o = err_q;

    // Ack watchdog: restarts on each command and each ack, counts strobed idle cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (cmd_fire) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (abort) begin
            to_cnt <= '0;
            err_q  <= 1'b1;
        end else if (ack_ok) begin
            to_cnt <= '0;
        end else if (stb) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    // Burst sequencer: command latch, write hold register, beat/address advance, read capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            rst_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rst_q      <= 1'b0;
            rd_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        we_q      <= cmd_we_i;
                        addr_q    <= cmd_addr_i;
                        len_q     <= cmd_len_i;
                        beat_q    <= '0;
                        hold_full <= 1'b0;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // wr_fire needs an empty hold and a write ack needs a full one, so they never collide.
                    if (wr_fire) begin
                        hold_full <= 1'b1;
                        hold_data <= wr_data_i;
                    end
                    if (abort) begin
                        hold_full <= 1'b0;
                        state     <= ST_DONE;
                    end else if (ack_ok) begin
                        addr_q    <= addr_q + AW'(SW);
                        beat_q    <= beat_q + 8'd1;
                        hold_full <= 1'b0;
                        if (!we_q) begin
                            rd_data_o  <= wb_dat_i;
                            rd_valid_o <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - scoreboard bench for wb_burst_master with a randomized Wishbone slave
`timescale 1ns/1ps
module tb_wb_burst_master;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_addr_i;
    logic [7:0]    cmd_len_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_valid_i, wr_ready_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o, busy_o, done_o, err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;

    always #5 clk = ~clk;

    wb_burst_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
    } beat_t;

    beat_t         exp_beats[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] wr_q[$];
    int            wr_stall_q[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] slave_mem[logic [AW-1:0]];

    int errors = 0;
    int checks = 0;
    int done_seen = 0, beats_seen = 0, stb_low_cnt = 0, stall_cnt = 0;
    int dly = 0, max_dly = 0, rnd_stall = 0;
    bit withhold = 0, rogue = 0, wr_hs = 0, rd_pend = 0;
    logic exp_err = 1'b0;
    beat_t mon_b;
    logic [DW-1:0] mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Contents of never-written slave locations, derived from the address.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {6'h15, a} ^ 32'h5A5A_0000;
    endfunction

    // Slave: random ack latency, optional withholding, optional stray acks with stb low.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            if (wb_cyc_o && wb_stb_o && !wb_rst_i && !withhold) begin
                if (dly > 0) dly--;
                else begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) slave_mem[wb_addr_o] = wb_dat_o;
                    else wb_dat_i = slave_mem.exists(wb_addr_o) ? slave_mem[wb_addr_o] : fill(wb_addr_o);
                    dly = $urandom_range(0, max_dly);
                end
            end else if (rogue && wb_cyc_o && !wb_stb_o) begin
                wb_ack_i = 1'b1;
                wb_dat_i = '1;
            end
        end
    end

    // Write-data source: per-word stall counted only in cycles the DUT is ready.
    initial begin
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (wr_hs && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                void'(wr_stall_q.pop_front());
            end
            wr_valid_i = 1'b0;
            if (wr_q.size() > 0) begin
                if (wr_stall_q[0] > 0) begin
                    if (wr_ready_o) wr_stall_q[0] = wr_stall_q[0] - 1;
                end else begin
                    wr_valid_i = 1'b1;
                    wr_data_i  = wr_q[0];
                end
            end
        end
    end

    // Monitor: pops expected beats / read words as the DUT presents them.
    always @(negedge clk) begin
        if (wb_rst_i) begin
            wr_hs   = 1'b0;
            rd_pend = 1'b0;
        end else begin
            wr_hs = wr_valid_i && wr_ready_o;
            if (rd_pend || rd_valid_o) begin
                check("rd_valid_timing", rd_valid_o, rd_pend);
                if (rd_valid_o) begin
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected: actual=0x%0h required=none", rd_data_o);
                    end else begin
                        mon_d = exp_rd.pop_front();
                        check("rd_data", rd_data_o, mon_d);
                    end
                end
            end
            rd_pend = 1'b0;
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                beats_seen++;
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: actual addr=0x%0h required=none", wb_addr_o);
                end else begin
                    mon_b = exp_beats.pop_front();
                    check("beat_addr", wb_addr_o, mon_b.addr);
                    check("beat_we", wb_we_o, mon_b.we);
                    check("beat_cti", wb_cti_o, mon_b.cti);
                    check("beat_sel", wb_sel_o, 4'hF);
                    if (mon_b.we) check("beat_wdata", wb_dat_o, mon_b.dat);
                end
                rd_pend = !wb_we_o;
            end
            if (busy_o && !done_o) check("cyc_in_xfer", wb_cyc_o, 1'b1);
            if (wb_cyc_o && !wb_stb_o) stb_low_cnt++;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) stall_cnt++;
            if (done_o) begin
                done_seen++;
                check("done_bus_idle", {wb_cyc_o, wb_stb_o, cmd_ready_o}, 3'b000);
                check("err_at_done", err_o, exp_err);
            end
        end
    end

    // Reference model: addresses advance by SW mod 2^AW; writes update ref_mem, reads predict from it.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] len,
                         input bit use_base, input logic [DW-1:0] base,
                         input int stall_at, input int stall_len, input bit expect_beats);
        beat_t b;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i * SW);
            if (we) begin
                d = use_base ? base + DW'(i) : DW'($urandom);
                ref_mem[a] = d;
                wr_q.push_back(d);
                wr_stall_q.push_back(i == stall_at ? stall_len : $urandom_range(0, rnd_stall));
            end else begin
                d = ref_mem.exists(a) ? ref_mem[a] : fill(a);
                if (expect_beats) exp_rd.push_back(d);
            end
            b.addr = a; b.we = we; b.dat = d;
            b.cti  = (i == int'(len)) ? 3'b111 : 3'b010;
            if (expect_beats) exp_beats.push_back(b);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready_o) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL cmd_accept_timeout: actual ready=0 required=1");
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_seen == d0) begin
            @(posedge clk);
            n++;
            if (n > 3000) begin
                checks++; errors++;
                $display("FAIL done_timeout: actual done_count=%0d required>%0d", done_seen, d0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        check("beats_drained", exp_beats.size(), 0);
        check("rd_drained", exp_rd.size(), 0);
    endtask

    logic [AW-1:0] ra;
    int d0, b0, n;

    initial begin
        wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o, rd_valid_o, wr_ready_o}, 9'd0);
        check("rst_sel_cti_addr", {wb_sel_o, wb_cti_o, wb_addr_o}, '0);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("ready_before_edge", cmd_ready_o, 1'b0);
        @(negedge clk);
        check("ready_after_release", cmd_ready_o, 1'b1);

        // 8-beat write of 0xA0.. at 0x100, then read it back
        max_dly = 2;
        d0 = done_seen;
        issue(1'b1, 26'h100, 8'd7, 1'b1, 32'hA0, -1, 0, 1'b1);
        wait_done(d0);
        repeat (3) @(posedge clk);
        check("write_one_done", done_seen, d0 + 1);
        d0 = done_seen;
        issue(1'b0, 26'h100, 8'd7, 1'b0, 0, -1, 0, 1'b1);
        wait_done(d0);

        // Starved write with stray acks while stb is low
        max_dly = 0; dly = 0; rogue = 1; stb_low_cnt = 0;
        b0 = beats_seen; d0 = done_seen;
        issue(1'b1, 26'h200, 8'd3, 1'b0, 0, 2, 5, 1'b1);
        wait_done(d0);
        rogue = 0;
        check("starve_stb_low_cycles", stb_low_cnt, 9);
        check("starve_beats", beats_seen - b0, 4);

        // Address wrap at the top of the AW space
        d0 = done_seen;
        issue(1'b1, 26'h3FFFFFC, 8'd1, 1'b0, 0, -1, 0, 1'b1);
        wait_done(d0);
        d0 = done_seen;
        issue(1'b0, 26'h3FFFFFC, 8'd1, 1'b0, 0, -1, 0, 1'b1);
        wait_done(d0);

        // Longest burst
        d0 = done_seen;
        issue(1'b0, 26'h8000, 8'd255, 1'b0, 0, -1, 0, 1'b1);
        wait_done(d0);

        // Randomized mix
        max_dly = 3; rnd_stall = 3;
        for (int k = 0; k < 12; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? 26'h3FFFF00 : 26'h0001000;
            ra = ra + AW'(4 * $urandom_range(0, 63));
            d0 = done_seen;
            issue(1'(($urandom_range(0, 1))), ra, 8'($urandom_range(0, 20)), 1'b0, 0, -1, 0, 1'b1);
            wait_done(d0);
        end
        rnd_stall = 0; max_dly = 1;

`ifdef WB_BURST_TIMEOUT_EN
        // Withheld ack trips the watchdog; next command clears err_o
        withhold = 1; exp_err = 1'b1; stall_cnt = 0; d0 = done_seen;
        issue(1'b0, 26'h3000, 8'd3, 1'b0, 0, -1, 0, 1'b0);
        wait_done(d0);
        check("timeout_stall_cycles", stall_cnt, TMO);
        check("timeout_err_sticky", err_o, 1'b1);
        withhold = 0; exp_err = 1'b0; d0 = done_seen;
        issue(1'b0, 26'h100, 8'd0, 1'b0, 0, -1, 0, 1'b1);
        check("err_cleared", err_o, 1'b0);
        wait_done(d0);
`else
        // Without the watchdog a withheld ack just stalls the burst
        withhold = 1; d0 = done_seen;
        issue(1'b0, 26'h3000, 8'd0, 1'b0, 0, -1, 0, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("stall_no_done", done_seen, d0);
        check("stall_cyc_held", {wb_cyc_o, wb_stb_o, err_o}, 3'b110);
        withhold = 0;
        wait_done(d0);
`endif

        // Reset in the middle of a 16-beat write
        d0 = done_seen; b0 = beats_seen;
        issue(1'b1, 26'h400, 8'd15, 1'b0, 0, -1, 0, 1'b1);
        n = 0;
        while (beats_seen - b0 < 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("reset_beat3_reached", beats_seen - b0 >= 3, 1'b1);
        wb_rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_drops_bus", {wb_cyc_o, wb_stb_o, busy_o, cmd_ready_o}, 4'b0000);
        exp_beats.delete(); exp_rd.delete(); wr_q.delete(); wr_stall_q.delete();
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("reset_ready_low", cmd_ready_o, 1'b0);
        @(negedge clk);
        check("reset_ready_high", cmd_ready_o, 1'b1);
        check("reset_no_done", done_seen, d0);

        d0 = done_seen;
        issue(1'b0, 26'h100, 8'd0, 1'b0, 0, -1, 0, 1'b1);
        wait_done(d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
